// File: rtl/dmem_access_ctrl.sv
// MEM-stage front end for the data memory: latches load/store requests, stalls on misses,
// retries until hit or timeout, and flags misaligned/out-of-range accesses. Optional DMEM_STATS_EN.
module dmem_access_ctrl #(
  parameter int unsigned MISS_TIMEOUT = 16,
  parameter int unsigned MEM_BYTES    = 64,
  parameter logic [31:0] FAULT_DATA   = 32'hBAD0DADA
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqRead,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  input  logic        DMemError,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        MisalignFault,
  output logic        AccessFault,
  output logic [15:0] MissCount
);

  localparam int unsigned TW = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_MISS   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   ldata_q, ldata_d;
  logic          lvalid_q, lvalid_d;
  logic          mfault_q, mfault_d;
  logic          afault_q, afault_d;

  logic busy;
  logic req;
  logic bad_addr;

  assign busy     = (state_q == S_ACCESS) || (state_q == S_MISS);
  assign req      = ReqRead | ReqWrite;
  // 33-bit sum so addresses near 2^32 cannot wrap into range
  assign bad_addr = (ReqAddr[1:0] != 2'b00) ||
                    (({1'b0, ReqAddr} + 33'd3) >= 33'(MEM_BYTES));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    tmo_d    = tmo_q;
    ldata_d  = ldata_q;
    lvalid_d = 1'b0;
    mfault_d = 1'b0;
    afault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          wr_d    = ReqWrite;
          rd_d    = ReqRead & ~ReqWrite;
          if (bad_addr) begin
            state_d  = S_DONE;
            lvalid_d = 1'b1;
            mfault_d = 1'b1;
            ldata_d  = FAULT_DATA;
          end else begin
            state_d = S_ACCESS;
            tmo_d   = '0;
          end
        end
      end
      S_ACCESS, S_MISS: begin
        if (!DMemError) begin
          if (rd_q) ldata_d = ReadData;
          state_d  = S_DONE;
          lvalid_d = 1'b1;
        end else if (tmo_q == TW'(MISS_TIMEOUT - 1)) begin
          // this miss cycle is the MISS_TIMEOUT-th consecutive one
          ldata_d  = FAULT_DATA;
          afault_d = 1'b1;
          lvalid_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          tmo_d   = tmo_q + TW'(1);
          state_d = S_MISS;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      tmo_q    <= '0;
      ldata_q  <= '0;
      lvalid_q <= 1'b0;
      mfault_q <= 1'b0;
      afault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      tmo_q    <= tmo_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
      mfault_q <= mfault_d;
      afault_q <= afault_d;
    end
  end

  assign memRead       = ~Rst & busy & rd_q;
  assign memWrite      = ~Rst & busy & wr_q & ~DMemError;
  assign Address       = addr_q;
  assign WriteData     = wdata_q;
  assign Stall         = busy | ((state_q == S_IDLE) & req);
  assign LoadData      = ldata_q;
  assign LoadValid     = lvalid_q;
  assign MisalignFault = mfault_q;
  assign AccessFault   = afault_q;

`ifdef DMEM_STATS_EN
  logic [15:0] mcnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mcnt_q <= '0;
    end else if (busy && DMemError && (mcnt_q != '1)) begin
      mcnt_q <= mcnt_q + 16'd1;
    end
  end

  assign MissCount = mcnt_q;
`else
  assign MissCount = '0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed requests push expected results,
// a monitor checks them on every LoadValid pulse.
module tb_dmem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ReqRead, ReqWrite;
  logic [31:0] ReqAddr, ReqWData;
  logic        memRead, memWrite;
  logic [31:0] Address, WriteData, ReadData, LoadData;
  logic        DMemError;
  logic        Stall, LoadValid, MisalignFault, AccessFault;
  logic [15:0] MissCount;
  logic        mem_init;

  logic [31:0] memw [16];

  typedef struct packed {
    logic [31:0] data;
    logic        mf;
    logic        af;
    logic [15:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  dmem_access_ctrl #(
    .MISS_TIMEOUT(16),
    .MEM_BYTES(64),
    .FAULT_DATA(32'hBAD0DADA)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqRead(ReqRead), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .memRead(memRead), .memWrite(memWrite), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .DMemError(DMemError), .Stall(Stall),
    .LoadData(LoadData), .LoadValid(LoadValid),
    .MisalignFault(MisalignFault), .AccessFault(AccessFault), .MissCount(MissCount)
  );

  assign ReadData = memw[Address[5:2]];

  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) memw[i] <= 32'h0;
      memw[2]  <= 32'h11223344;
      memw[5]  <= 32'h55667788;
      memw[15] <= 32'hA5A50F0F;
    end else if (memWrite) begin
      memw[Address[5:2]] <= WriteData;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (!Rst && LoadValid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_LoadValid", {31'b0, LoadValid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("LoadData", LoadData, e.data);
        chk("MisalignFault", {31'b0, MisalignFault}, {31'b0, e.mf});
        chk("AccessFault", {31'b0, AccessFault}, {31'b0, e.af});
        chk("MissCount", {16'b0, MissCount}, {16'b0, e.mc});
      end
    end
  end

  task automatic do_req(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata, input int nmiss,
                        input logic [31:0] exp_data, input logic mf, input logic af,
                        input logic [15:0] mc_stats,
                        input int exp_stall, input int exp_rd, input int exp_wr);
    exp_t e;
    int stalls = 0;
    int rds = 0;
    int wrs = 0;
    int wr_miss = 0;
    int c = 0;
    bit done = 1'b0;
    e.data = exp_data;
    e.mf   = mf;
    e.af   = af;
`ifdef DMEM_STATS_EN
    e.mc   = mc_stats;
`else
    e.mc   = 16'd0;
`endif
    exp_q.push_back(e);
    @(negedge Clk);
    ReqRead  = rd;
    ReqWrite = wr;
    ReqAddr  = addr;
    ReqWData = wdata;
    while (!done && c < 100) begin
      DMemError = (c >= 1) && (c <= nmiss);
      #1;
      if (!Stall) begin
        done      = 1'b1;
        ReqRead   = 1'b0;
        ReqWrite  = 1'b0;
        DMemError = 1'b0;
      end else begin
        stalls++;
        if (memRead) rds++;
        if (memWrite) begin
          wrs++;
          if (DMemError) wr_miss++;
        end
        @(negedge Clk);
        c++;
      end
    end
    if (!done) begin
      chk({name, "_stall_timeout"}, {31'b0, done}, 32'd1);
      ReqRead   = 1'b0;
      ReqWrite  = 1'b0;
      DMemError = 1'b0;
    end
    chk({name, "_stall_cycles"}, stalls, exp_stall);
    chk({name, "_memRead_cycles"}, rds, exp_rd);
    chk({name, "_memWrite_cycles"}, wrs, exp_wr);
    chk({name, "_write_during_miss"}, wr_miss, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; mem_init = 1'b1;
    ReqRead = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0; DMemError = 1'b0;
    @(negedge Clk); @(negedge Clk);
    chk("rst_memRead", {31'b0, memRead}, 32'd0);
    chk("rst_memWrite", {31'b0, memWrite}, 32'd0);
    Rst = 1'b0; mem_init = 1'b0;
    #1;
    chk("rst_LoadValid", {31'b0, LoadValid}, 32'd0);
    chk("rst_LoadData", LoadData, 32'd0);
    chk("rst_MissCount", {16'b0, MissCount}, 32'd0);
    chk("rst_faults", {30'b0, MisalignFault, AccessFault}, 32'd0);
    chk("rst_Stall", {31'b0, Stall}, 32'd0);
    chk("rst_Address", Address, 32'd0);
    chk("rst_WriteData", WriteData, 32'd0);

    //      name          rd    wr    addr      wdata          nmiss data           mf    af    mc  stall rd wr
    do_req("load_hit",    1'b1, 1'b0, 32'h08, 32'h0,         0,   32'h11223344, 1'b0, 1'b0, 0,  2,  1, 0);
    do_req("load_miss3",  1'b1, 1'b0, 32'h08, 32'h0,         3,   32'h11223344, 1'b0, 1'b0, 3,  5,  4, 0);
    do_req("store_miss2", 1'b0, 1'b1, 32'h04, 32'hCAFEF00D,  2,   32'h11223344, 1'b0, 1'b0, 5,  4,  0, 1);
    do_req("readback_4",  1'b1, 1'b0, 32'h04, 32'h0,         0,   32'hCAFEF00D, 1'b0, 1'b0, 5,  2,  1, 0);
    do_req("load_tmo",    1'b1, 1'b0, 32'h10, 32'h0,         100, 32'hBAD0DADA, 1'b0, 1'b1, 21, 17, 16, 0);
    do_req("store_tmo",   1'b0, 1'b1, 32'h14, 32'hDEADBEEF,  100, 32'hBAD0DADA, 1'b0, 1'b1, 37, 17, 0, 0);
    do_req("readback_14", 1'b1, 1'b0, 32'h14, 32'h0,         0,   32'h55667788, 1'b0, 1'b0, 37, 2,  1, 0);
    do_req("misalign_6",  1'b1, 1'b0, 32'h06, 32'h0,         0,   32'hBAD0DADA, 1'b1, 1'b0, 37, 1,  0, 0);
    do_req("range_3E",    1'b0, 1'b1, 32'h3E, 32'h12345678,  0,   32'hBAD0DADA, 1'b1, 1'b0, 37, 1,  0, 0);
    do_req("range_40",    1'b1, 1'b0, 32'h40, 32'h0,         0,   32'hBAD0DADA, 1'b1, 1'b0, 37, 1,  0, 0);
    do_req("edge_3C",     1'b1, 1'b0, 32'h3C, 32'h0,         0,   32'hA5A50F0F, 1'b0, 1'b0, 37, 2,  1, 0);
    do_req("rd_wr_both",  1'b1, 1'b1, 32'h20, 32'h0BADBEEF,  0,   32'hA5A50F0F, 1'b0, 1'b0, 37, 2,  0, 1);
    do_req("readback_20", 1'b1, 1'b0, 32'h20, 32'h0,         0,   32'h0BADBEEF, 1'b0, 1'b0, 37, 2,  1, 0);

    // reset while the load sits in MISS
    @(negedge Clk);
    ReqRead = 1'b1; ReqAddr = 32'h08;
    @(negedge Clk); DMemError = 1'b1;
    @(negedge Clk); DMemError = 1'b1;
    @(negedge Clk);
    Rst = 1'b1; ReqRead = 1'b0;
    #1;
    chk("rstmid_memRead", {31'b0, memRead}, 32'd0);
    chk("rstmid_memWrite", {31'b0, memWrite}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0; DMemError = 1'b0;
    #1;
    chk("rstmid_Stall", {31'b0, Stall}, 32'd0);
    chk("rstmid_memRead_idle", {31'b0, memRead}, 32'd0);
    chk("rstmid_LoadValid", {31'b0, LoadValid}, 32'd0);
    chk("rstmid_LoadData", LoadData, 32'd0);
    chk("rstmid_MissCount", {16'b0, MissCount}, 32'd0);
    chk("rstmid_faults", {30'b0, MisalignFault, AccessFault}, 32'd0);
    chk("rstmid_Address", Address, 32'd0);
    @(negedge Clk); @(negedge Clk);
    chk("rstmid_no_result", {31'b0, LoadValid}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
